imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes instruction memory over a byte stream, the write-side counterpart to the instruction fetch unit that reads it. It takes a framed stream (16-bit word count, then big-endian 32-bit words), packs bytes into words, and issues one write per word to the instruction ROM port starting at the fetch reset address. It holds the core in reset until a load completes cleanly.

## Interface
- `DEPTH_LOG2`, default 10: log2 of instruction memory depth in words (1024).
- `BASE_ADDR`, default 32'h0000_3000: byte address of word 0; equals the fetch reset PC.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `in_valid` input 1: byte on `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `we` output 1: instruction memory write strobe, one cycle per word.
- `waddr` output 32: byte address of write; memory index is `waddr[DEPTH_LOG2+1:2]`.
- `wdata` output 32: word to write.
- `cpu_hold` output 1: keep core (including PC) in reset.
- `done` output 1: load completed; level.
- `err` output 1: header word count exceeded depth; level.

## Operation
- States: IDLE, CNT_HI, CNT_LO, DATA, DONE, ERR.
- Reset: state IDLE; `in_ready`=0, `we`=0, `waddr`=BASE_ADDR, `wdata`=0, `cpu_hold`=1, `done`=0, `err`=0; word index, byte count and count register cleared.
- IDLE/DONE/ERR + `start` -> CNT_HI; clears `done`, `err`, word index, byte count. `start` is ignored in CNT_HI, CNT_LO and DATA.
- A byte is accepted on a rising edge with `in_valid && in_ready`. `in_ready`=1 exactly in CNT_HI, CNT_LO and DATA.
- CNT_HI: accepted byte -> count[15:8]; go to CNT_LO.
- CNT_LO: accepted byte -> count[7:0]. Full count is 0 -> DONE. Count > 2^DEPTH_LOG2 -> ERR. Otherwise -> DATA.
- DATA: bytes are packed MSB first: byte 0 -> [31:24], byte 3 -> [7:0]. On the 4th byte: `we`=1 next cycle, with `wdata` = packed word and `waddr` = BASE_ADDR + 4*index; index increments. If that word was word count-1, go to DONE.
- `cpu_hold` = 0 only in DONE; it is 1 in every other state, including ERR.
- `done` = 1 in DONE. `err` = 1 in ERR. Neither is asserted in any other state.
- Address arithmetic is 32-bit. The index is DEPTH_LOG2+1 bits wide, so count = 2^DEPTH_LOG2 is legal and writes the final word at BASE_ADDR + 4*(2^DEPTH_LOG2 − 1).

## Timing
- Streaming: `in_ready` stays high, so one byte per cycle is sustainable; there is no backpressure inside a frame.
- Write latency: `we` is registered, high in the cycle after the edge that accepted the 4th byte. `we`, `waddr` and `wdata` are valid together for exactly one cycle.
- DONE entry happens on that same edge. Therefore `we` for the last word, `done`=1 and `cpu_hold`=0 first appear in the same cycle.
- The core samples `cpu_hold` as its reset. It fetches from BASE_ADDR no earlier than the cycle after `cpu_hold` falls, which is after the final write.
- ERR and DONE entry from CNT_LO take effect on the edge that accepted the low count byte.
- Reset mid-frame: returns to IDLE next edge. Any partial word is discarded, no `we` is issued, and `cpu_hold` returns to 1.
- `start` in the same cycle as `reset`: reset wins.
- Restart from DONE re-asserts `cpu_hold` the cycle after `start`.

## Structure
- Shared package holds:
  - the state enum;
  - `IMEM_BASE` = 32'h0000_3000, shared with fetch so the reset PC and loader base cannot diverge;
  - the header width constant (16).
- One sub-module, `byte_packer`. It has a 2-bit byte counter and a 32-bit shift register, takes accept/byte/clear inputs, and outputs a word plus a one-cycle `word_valid`. The FSM and address counter stay in `imem_loader`.

## Test plan
- Basic load: `start`, then bytes 00 02 | 12 34 56 78 | 9A BC DE F0, one per cycle.
  - Expect `we` at 0x3000/0x12345678, then at 0x3004/0x9ABCDEF0.
  - `done`=1 and `cpu_hold`=0 in the same cycle as the second `we`.
- Gapped stream: same frame with `in_valid` dropped for 1–3 cycles between bytes.
  - Expect identical writes, each one cycle after its 4th byte.
- Zero count: header 00 00.
  - Expect no `we`, `done`=1 the cycle after the low byte, `in_ready`=0 afterwards.
- Overflow: header 04 01 (1025).
  - Expect `err`=1, `cpu_hold`=1, no `we`.
  - Header 04 00 followed by 4096 bytes: last write at 0x3FFC, then `done`.
- Reset mid-word: send 00 01 AA BB, then assert `reset`.
  - Expect no `we`, IDLE, `cpu_hold`=1.
  - A new `start` plus a full frame writes the correct word at 0x3000.
- Reload: after DONE, `start` plus header 00 01 and word 0000000C.
  - `cpu_hold` rises the cycle after `start`.
  - Single write at 0x3000/0x0000000C, then `done`.
  - `start` pulses during DATA are ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the boot-time instruction memory loader.
//   - loader_state_t : loader FSM state encoding
//   - IMEM_BASE      : byte address of instruction word 0. The fetch unit
//                      uses the same constant as its reset PC, so the two
//                      cannot drift apart.
//   - HDR_WIDTH      : width of the frame header (word count) in bits
//   - wordByteAddr   : byte address of a word index relative to a base
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_t;

    localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
    localparam int          HDR_WIDTH = 16;

    // Words are 4 bytes, so the byte offset is the index shifted by 2.
    // The sum wraps at 32 bits, like the core's own address arithmetic.
    function automatic logic [31:0] wordByteAddr(input logic [31:0] base,
                                                 input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Packs a byte stream into 32-bit big-endian words: the first byte of a
// word lands in [31:24], the fourth in [7:0].
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_clear           : discard any partial word and restart at byte 0
//   i_accept          : i_byte is consumed on this edge
//   i_byte            : stream byte
//   o_word            : packed word; valid while o_word_valid is high
//   o_word_valid      : one-cycle pulse, the cycle after the 4th byte
//   o_word_complete   : this cycle's accept completes a word (combinational,
//                       lets the parent act on the same edge as the packer)
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_word_complete
);

    logic [1:0]  r_byte_cnt;
    logic [31:0] r_shift;
    logic        r_word_valid;

    assign o_word_complete = i_accept && (r_byte_cnt == 2'd3);

    // After the 4th byte the shift register holds exactly the packed word,
    // and it cannot change before the next accepted byte, so it doubles as
    // the write data for the valid cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt   <= 2'd0;
            r_shift      <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_byte_cnt <= 2'd0;
                r_shift    <= 32'd0;
            end else if (i_accept) begin
                r_shift    <= {r_shift[23:0], i_byte};
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (o_word_complete) begin
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_shift;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time loader: receives a framed byte stream (16-bit big-endian word
// count, then big-endian 32-bit words) and writes each word into
// instruction memory starting at BASE_ADDR. Keeps the core in reset until
// a load finishes cleanly.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid    : in_data holds a valid byte
//   in_data     : stream byte
//   in_ready    : loader accepts a byte this cycle
//   we          : instruction memory write strobe, one cycle per word
//   waddr       : byte address of the write
//   wdata       : word to write
//   cpu_hold    : hold the core (and its PC) in reset
//   done        : load completed (level)
//   err         : header word count exceeded memory depth (level)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = IMEM_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // Largest legal word count; the index carries one extra bit so a full
    // memory's worth of words can be counted.
    localparam logic [HDR_WIDTH:0] MAX_WORDS = (HDR_WIDTH+1)'(2 ** DEPTH_LOG2);

    loader_state_t          r_state;
    logic [HDR_WIDTH-1:0]   r_count;
    logic [DEPTH_LOG2:0]    r_index;
    logic [31:0]            r_waddr;
    logic                   r_in_ready;
    logic                   r_cpu_hold;
    logic                   r_done;
    logic                   r_err;

    loader_state_t          w_next_state;
    logic                   w_accept;
    logic                   w_start_load;
    logic [HDR_WIDTH-1:0]   w_full_count;
    logic                   w_last_word;
    logic                   w_word_complete;
    logic                   w_word_valid;
    logic [31:0]            w_word;

    assign w_accept     = in_valid && r_in_ready;
    assign w_start_load = start && ((r_state == ST_IDLE) ||
                                    (r_state == ST_DONE) ||
                                    (r_state == ST_ERR));
    assign w_full_count = {r_count[HDR_WIDTH-1:8], in_data};
    assign w_last_word  = (HDR_WIDTH'(r_index) == (r_count - HDR_WIDTH'(1)));

    byte_packer u_packer (
        .clk             (clk),
        .reset           (reset),
        .i_clear         (w_start_load),
        .i_accept        (w_accept && (r_state == ST_DATA)),
        .i_byte          (in_data),
        .o_word          (w_word),
        .o_word_valid    (w_word_valid),
        .o_word_complete (w_word_complete)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_next_state = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (w_accept) w_next_state = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (w_accept) begin
                    if (w_full_count == '0)
                        w_next_state = ST_DONE;
                    else if ({1'b0, w_full_count} > MAX_WORDS)
                        w_next_state = ST_ERR;
                    else
                        w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_complete && w_last_word) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state, so they change on
    // the same edge as the state itself. In particular the final write's
    // strobe, done and the release of cpu_hold all appear together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_waddr    <= BASE_ADDR;
            r_in_ready <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == ST_CNT_HI) ||
                          (w_next_state == ST_CNT_LO) ||
                          (w_next_state == ST_DATA);
            r_cpu_hold <= (w_next_state != ST_DONE);
            r_done     <= (w_next_state == ST_DONE);
            r_err      <= (w_next_state == ST_ERR);

            if (w_start_load) begin
                r_index <= '0;
            end

            if (w_accept && (r_state == ST_CNT_HI)) begin
                r_count[HDR_WIDTH-1:8] <= in_data;
            end
            if (w_accept && (r_state == ST_CNT_LO)) begin
                r_count[7:0] <= in_data;
            end

            // Address is captured on the 4th-byte edge so it lines up with
            // the packer's registered word_valid in the following cycle.
            if ((r_state == ST_DATA) && w_word_complete) begin
                r_waddr <= wordByteAddr(BASE_ADDR, 32'(r_index));
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign we       = w_word_valid;
    assign waddr    = r_waddr;
    assign wdata    = w_word;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. Frames are built from random or
// fixed word lists; expected writes come from the frame contents (word i
// goes to BASE + 4*i) and the status rules of the loader.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam int          MAX_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int testsRun  = 0;
    int testsFail = 0;

    logic [31:0] frameWords [$];

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput("start_cpu_hold", cpu_hold, 1);
        checkOutput("start_in_ready", in_ready, 1);
        checkOutput("start_done", done, 0);
        checkOutput("start_err", err, 0);
        checkOutput("start_we", we, 0);
    endtask

    // Optional idle gap, then one byte presented for exactly one edge.
    task automatic sendByte(input logic [7:0] b, input int gapMax, input bit noise);
        int gaps;
        gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        for (int j = 0; j < gaps; j++) begin
            in_valid = 1'b0;
            stepCycle();
            checkOutput("gap_we", we, 0);
        end
        checkOutput("byte_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = b;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        stepCycle();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Full load of frameWords with the given header count. Expected
    // behaviour is derived from the count: 0 -> immediate done,
    // above memory depth -> error, otherwise one write per word.
    task automatic applyStimulus(input logic [15:0] count, input int gapMax,
                                 input bit noise);
        logic [31:0] word;
        pulseStart();
        sendByte(count[15:8], gapMax, 1'b0);
        checkOutput("hdr_we", we, 0);
        sendByte(count[7:0], gapMax, 1'b0);
        if (count == 16'd0) begin
            checkOutput("zero_done", done, 1);
            checkOutput("zero_hold", cpu_hold, 0);
            checkOutput("zero_ready", in_ready, 0);
            checkOutput("zero_we", we, 0);
        end else if (int'(count) > MAX_WORDS) begin
            checkOutput("ovf_err", err, 1);
            checkOutput("ovf_hold", cpu_hold, 1);
            checkOutput("ovf_ready", in_ready, 0);
            checkOutput("ovf_done", done, 0);
            stepCycle();
            checkOutput("ovf_we", we, 0);
            checkOutput("ovf_err_hold", err, 1);
        end else begin
            for (int i = 0; i < int'(count); i++) begin
                word = frameWords[i];
                for (int k = 0; k < 4; k++) begin
                    sendByte(word[31-8*k -: 8], gapMax, noise);
                    if (k < 3) begin
                        checkOutput("mid_we", we, 0);
                    end
                end
                checkOutput("word_we", we, 1);
                checkOutput("word_addr", waddr, BASE + 32'(4 * i));
                checkOutput("word_data", wdata, word);
                if (i == int'(count) - 1) begin
                    checkOutput("last_done", done, 1);
                    checkOutput("last_hold", cpu_hold, 0);
                    checkOutput("last_ready", in_ready, 0);
                end else begin
                    checkOutput("mid_done", done, 0);
                    checkOutput("mid_hold", cpu_hold, 1);
                end
            end
            stepCycle();
            checkOutput("post_we", we, 0);
            checkOutput("post_done", done, 1);
        end
    endtask

    task automatic randomWords(input int n);
        frameWords.delete();
        for (int i = 0; i < n; i++) frameWords.push_back($urandom);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) stepCycle();
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_waddr", waddr, BASE);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_hold", cpu_hold, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        reset = 1'b0;
        stepCycle();
        checkOutput("idle_ready", in_ready, 0);

        // Basic and gapped load of the reference frame.
        frameWords = '{32'h1234_5678, 32'h9ABC_DEF0};
        applyStimulus(16'd2, 0, 1'b0);
        applyStimulus(16'd2, 3, 1'b0);

        // Zero count and overflow headers.
        frameWords.delete();
        applyStimulus(16'd0, 0, 1'b0);
        applyStimulus(16'h0401, 0, 1'b0);

        // Random frames with random gaps and stray start pulses.
        for (int n = 0; n < 6; n++) begin
            int cnt;
            cnt = int'($urandom_range(1, 6));
            randomWords(cnt);
            applyStimulus(16'(cnt), int'($urandom_range(0, 3)), 1'b1);
        end
        applyStimulus(16'($urandom_range(MAX_WORDS + 1, 65535)), 1, 1'b0);

        // Full memory depth: last write lands at BASE + 0xFFC.
        randomWords(MAX_WORDS);
        applyStimulus(16'h0400, 0, 1'b0);

        // Reset in the middle of a word; reset also beats a coincident start.
        pulseStart();
        sendByte(8'h00, 0, 1'b0);
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'hAA, 0, 1'b0);
        sendByte(8'hBB, 0, 1'b0);
        checkOutput("rmid_we", we, 0);
        reset = 1'b1;
        start = 1'b1;
        stepCycle();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rmid_ready", in_ready, 0);
        checkOutput("rmid_hold", cpu_hold, 1);
        checkOutput("rmid_done", done, 0);
        checkOutput("rmid_we", we, 0);
        stepCycle();
        checkOutput("rmid_we2", we, 0);
        checkOutput("rmid_idle", in_ready, 0);
        frameWords = '{32'hCAFE_F00D};
        applyStimulus(16'd1, 0, 1'b0);

        // Reload from DONE with start pulses sprinkled over the data bytes.
        frameWords = '{32'h0000_000C};
        applyStimulus(16'd1, 0, 1'b1);
        repeat (2) stepCycle();
        checkOutput("final_done", done, 1);
        checkOutput("final_hold", cpu_hold, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
